// File: rtl/cbu_pipe.sv
// cbu_pipe: register file feeding a two-stage ALU pipeline (EX, OUT) with
// valid/ready handshakes, EX->ID operand forwarding and carry/zero flags.
// Instruction format: {op[2:0], ra, rb, rd}. Register 0 always reads zero.
module cbu_pipe #(
    parameter int WIDTH  = 8,
    parameter int REG_AW = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ext_we,
    input  logic [REG_AW-1:0]       ext_waddr,
    input  logic [WIDTH-1:0]        ext_wdata,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3+3*REG_AW-1:0]   in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [REG_AW-1:0]       out_rd,
    output logic                    out_carry,
    output logic                    out_zero
);

    localparam int NREGS = 2 ** REG_AW;
    localparam int IW    = 3 + 3 * REG_AW;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011,
        OP_CMP = 3'b100,
        OP_AND = 3'b101,
        OP_XOR = 3'b110,
        OP_SHL = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0]  regs [NREGS];

    logic              advance;
    logic              accept;
    logic              wb_en;

    logic [2:0]        id_op;
    logic [REG_AW-1:0] id_ra;
    logic [REG_AW-1:0] id_rb;
    logic [REG_AW-1:0] id_rd;
    logic [WIDTH-1:0]  id_a;
    logic [WIDTH-1:0]  id_b;

    logic              ex_valid;
    alu_op_e           ex_op;
    logic [WIDTH-1:0]  ex_a;
    logic [WIDTH-1:0]  ex_b;
    logic [REG_AW-1:0] ex_rd;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic              alu_zero;

    // The whole pipe moves only when the output register is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign wb_en    = advance && ex_valid && (ex_rd != '0);

    assign id_op = in_instr[IW-1 -: 3];
    assign id_ra = in_instr[3*REG_AW-1 -: REG_AW];
    assign id_rb = in_instr[2*REG_AW-1 -: REG_AW];
    assign id_rd = in_instr[REG_AW-1:0];

    // Operand read with forwarding of the result currently in EX (not yet written back).
    always_comb begin
        id_a = regs[id_ra];
        id_b = regs[id_rb];
        if (ex_valid && (ex_rd != '0) && (ex_rd == id_ra)) begin
            id_a = alu_res;
        end
        if (ex_valid && (ex_rd != '0) && (ex_rd == id_rb)) begin
            id_b = alu_res;
        end
    end

    // Register file: writeback takes priority over an external write to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_en && (ex_rd == REG_AW'(i))) begin
                    regs[i] <= alu_res;
                end else if (ext_we && (ext_waddr == REG_AW'(i))) begin
                    regs[i] <= ext_wdata;
                end
            end
        end
    end

    // EX stage register: loads a new instruction (or a bubble) whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op    <= OP_ADD;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
        end else if (advance) begin
            ex_valid <= accept;
            if (accept) begin
                ex_op <= alu_op_e'(id_op);
                ex_a  <= id_a;
                ex_b  <= id_b;
                ex_rd <= id_rd;
            end
        end
    end

    // ALU on the EX operands; carry is carry-out for additions, borrow for subtractions.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (ex_op)
            OP_ADD: {alu_carry, alu_res} = {1'b0, ex_a} + {1'b0, ex_b};
            OP_SUB: begin
                alu_res   = ex_a - ex_b;
                alu_carry = (ex_a < ex_b);
            end
            OP_INC: {alu_carry, alu_res} = {1'b0, ex_a} + (WIDTH+1)'(1);
            OP_DEC: begin
                alu_res   = ex_a - WIDTH'(1);
                alu_carry = (ex_a == '0);
            end
            OP_CMP: alu_res = {{(WIDTH-3){1'b0}}, (ex_a > ex_b), (ex_a < ex_b), (ex_a == ex_b)};
            OP_AND: alu_res = ex_a & ex_b;
            OP_XOR: alu_res = ex_a ^ ex_b;
            OP_SHL: begin
                alu_res   = {ex_a[WIDTH-2:0], 1'b0};
                alu_carry = ex_a[WIDTH-1];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
        alu_zero = (alu_res == '0);
    end

    // OUT stage register: held while the consumer stalls, payload only updated by real results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            out_valid <= ex_valid;
            if (ex_valid) begin
                out_data  <= alu_res;
                out_rd    <= ex_rd;
                out_carry <= alu_carry;
                out_zero  <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_cbu_pipe.sv
// Testbench for cbu_pipe: directed literal cases plus randomized traffic checked
// against an in-order architectural model (each accepted instruction sees every
// earlier result, ext writes land at their edge).
module tb_cbu_pipe;

    localparam int W  = 8;
    localparam int AW = 2;
    localparam int IW = 3 + 3 * AW;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, INC = 3'd2, DEC = 3'd3,
                           CMP = 3'd4, AND_ = 3'd5, XOR_ = 3'd6, SHL = 3'd7;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [AW-1:0] rd;
        logic          c;
        logic          z;
    } res_t;

    logic          clk;
    logic          rst;
    logic          ext_we;
    logic [AW-1:0] ext_waddr;
    logic [W-1:0]  ext_wdata;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_rd;
    logic          out_carry;
    logic          out_zero;

    res_t          q[$];
    res_t          dlog[$];
    logic [W-1:0]  mregs[4];
    int            checks;
    int            errors;
    bit            ext_skip;

    cbu_pipe #(.WIDTH(W), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_carry(out_carry), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [AW-1:0] rd);
        int unsigned ai, bi, r, c, m;
        res_t e;
        ai = a; bi = b; r = 0; c = 0; m = (1 << W) - 1;
        case (op)
            ADD:  begin r = ai + bi; c = (r > m) ? 1 : 0; end
            SUB:  begin r = ai - bi; c = (ai < bi) ? 1 : 0; end
            INC:  begin r = ai + 1;  c = (r > m) ? 1 : 0; end
            DEC:  begin r = ai - 1;  c = (ai == 0) ? 1 : 0; end
            CMP:  r = ((ai > bi) ? 4 : 0) + ((ai < bi) ? 2 : 0) + ((ai == bi) ? 1 : 0);
            AND_: r = ai & bi;
            XOR_: r = ai ^ bi;
            default: begin r = ai * 2; c = (ai >> (W - 1)) & 1; end
        endcase
        r = r & m;
        e.data = r[W-1:0];
        e.rd   = rd;
        e.c    = c[0];
        e.z    = (r == 0);
        return e;
    endfunction

    // Scoreboard: model updates on accept/ext write, DUT output checked whenever valid.
    always @(negedge clk) begin
        res_t e;
        logic [2:0]    op;
        logic [AW-1:0] ra, rb, rd;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) mregs[i] = '0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    chk("out_data", out_data, q[0].data);
                    chk("out_rd", out_rd, q[0].rd);
                    chk("out_carry", out_carry, q[0].c);
                    chk("out_zero", out_zero, q[0].z);
                    if (out_ready) begin
                        void'(q.pop_front());
                        dlog.push_back(res_t'{out_data, out_rd, out_carry, out_zero});
                    end
                end
            end
            if (in_valid && in_ready) begin
                {op, ra, rb, rd} = in_instr;
                e = model(op, mregs[ra], mregs[rb], rd);
                q.push_back(e);
                if (rd != 0) mregs[rd] = e.data;
            end
            if (ext_we && !ext_skip && ext_waddr != 0) mregs[ext_waddr] = ext_wdata;
        end
    end

    task automatic send(input logic [2:0] op, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic [AW-1:0] rd);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = {op, ra, rb, rd};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic ext(input logic [AW-1:0] a, input logic [W-1:0] d);
        @(posedge clk); #1;
        in_valid = 1'b0;
        ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
        @(posedge clk); #1;
        ext_we = 1'b0;
    endtask

    task automatic wait_deliv(input int target);
        for (int i = 0; i < 60; i++) begin
            if (dlog.size() >= target) return;
            @(posedge clk); #2;
        end
        chk("deliver_timeout", dlog.size(), target);
    endtask

    task automatic chk_res(input string name, input int idx, input logic [W-1:0] d,
                           input logic [AW-1:0] rd, input logic c, input logic z);
        if (idx >= dlog.size()) begin
            chk({name, "_missing"}, dlog.size(), idx + 1);
        end else begin
            chk({name, "_data"}, dlog[idx].data, d);
            chk({name, "_rd"}, dlog[idx].rd, rd);
            chk({name, "_carry"}, dlog[idx].c, c);
            chk({name, "_zero"}, dlog[idx].z, z);
        end
    endtask

    initial begin
        int base;
        bit ok;
        logic [AW-1:0] a;
        checks = 0; errors = 0; ext_skip = 0;
        rst = 1'b1; ext_we = 0; ext_waddr = '0; ext_wdata = '0;
        in_valid = 0; in_instr = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_out_zero", out_zero, 0);

        // ADD with latency check
        ext(1, 8'd5); ext(2, 8'd3);
        send(ADD, 1, 2, 3);
        idle();
        @(negedge clk);
        chk("lat_n_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_n1_valid", out_valid, 1);
        chk("lat_data", out_data, 8);
        chk("lat_rd", out_rd, 3);
        chk("lat_carry", out_carry, 0);
        chk("lat_zero", out_zero, 0);

        // back-to-back dependent pair
        wait_deliv(dlog.size() + 1);
        base = dlog.size();
        send(ADD, 1, 2, 3); send(SUB, 3, 2, 1); idle();
        wait_deliv(base + 2);
        chk_res("fwd_add", base, 8'd8, 2'd3, 0, 0);
        chk_res("fwd_sub", base + 1, 8'd5, 2'd1, 0, 0);

        // wraparound
        ext(1, 8'hFF);
        base = dlog.size();
        send(INC, 1, 0, 2); send(DEC, 0, 0, 2); idle();
        wait_deliv(base + 2);
        chk_res("inc_wrap", base, 8'h00, 2'd2, 1, 1);
        chk_res("dec_r0", base + 1, 8'hFF, 2'd2, 1, 0);

        // compare and r0 destination
        ext(1, 8'd5); ext(2, 8'd3);
        base = dlog.size();
        send(CMP, 2, 1, 3); send(CMP, 1, 1, 0); send(ADD, 0, 0, 3); idle();
        wait_deliv(base + 3);
        chk_res("cmp_lt", base, 8'h02, 2'd3, 0, 0);
        chk_res("cmp_eq", base + 1, 8'h01, 2'd0, 0, 0);
        chk_res("r0_reads0", base + 2, 8'h00, 2'd3, 0, 1);

        // ext write colliding with writeback on the same edge: writeback wins
        base = dlog.size();
        send(ADD, 1, 2, 3);
        @(posedge clk); #1;
        in_valid = 0; ext_skip = 1; ext_we = 1; ext_waddr = 3; ext_wdata = 8'h77;
        @(posedge clk); #1;
        ext_we = 0; ext_skip = 0;
        send(XOR_, 3, 0, 0); idle();
        wait_deliv(base + 2);
        chk_res("wb_wins", base + 1, 8'd8, 2'd0, 0, 0);

        // backpressure with three queued instructions
        idle();
        out_ready = 1'b0;
        base = dlog.size();
        send(ADD, 1, 2, 3); send(INC, 3, 0, 3);
        @(posedge clk); #1;
        in_instr = {SUB, 2'd3, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_data", out_data, 8);
            chk("stall_no_deliv", dlog.size(), base);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in_ready", in_ready, 1);
        idle();
        wait_deliv(base + 3);
        chk_res("bp_a", base, 8'd8, 2'd3, 0, 0);
        chk_res("bp_b", base + 1, 8'd9, 2'd3, 0, 0);
        chk_res("bp_c", base + 2, 8'd4, 2'd2, 0, 0);

        // reset with two in flight
        idle();
        out_ready = 1'b0;
        send(ADD, 1, 2, 3); send(SHL, 1, 0, 2);
        @(posedge clk); #1;
        in_valid = 0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        base = dlog.size();
        send(ADD, 1, 2, 3); idle();
        wait_deliv(base + 1);
        send(INC, 2, 0, 1); idle();
        wait_deliv(base + 2);
        chk_res("post_rst_add", base, 8'd0, 2'd3, 0, 1);
        chk_res("post_rst_inc", base + 1, 8'd1, 2'd1, 0, 0);

        // randomized traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = IW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            ext_we    = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                a  = AW'($urandom);
                ok = !(in_valid && in_instr[AW-1:0] == a);
                foreach (q[i]) if (q[i].rd == a) ok = 0;
                if (ok) begin
                    ext_we = 1'b1; ext_waddr = a; ext_wdata = W'($urandom);
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 0; ext_we = 0; out_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
